// File: rtl/sampler.sv
// sampler: divider-paced channel sampler with per-byte group masking and a test-pattern source.
// Define SAMPLER_SYNC_EN to insert a 2-flop synchronizer on chls_i (adds 2 cycles of input latency).
module sampler #(
   parameter int CHLS = 32,
   parameter int WDIV = 24
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [31:0]     cmd_i,
   input  logic            set_div_i,
   input  logic            set_flags_i,
   input  logic            en_i,
   input  logic [CHLS-1:0] chls_i,
   output logic [CHLS-1:0] smpls_o,
   output logic            stb_o
);

   generate
      if (CHLS < 1 || CHLS > 32) begin : g_chls_err
         $error("sampler: CHLS must be in 1..32");
      end
      if (WDIV < 1 || WDIV > 32) begin : g_wdiv_err
         $error("sampler: WDIV must be in 1..32");
      end
   endgenerate

   logic [WDIV-1:0] r_div;
   logic [WDIV-1:0] r_cnt;
   logic [3:0]      r_grp_dis;
   logic            r_test;
   logic [31:0]     r_tpat;
   logic [CHLS-1:0] r_smpls;
   logic            r_stb;

   logic [CHLS-1:0] w_chls;
   logic [CHLS-1:0] w_keep;
   logic [CHLS-1:0] w_src;
   logic [CHLS-1:0] w_masked;
   logic            w_fire;
   logic            w_unused_ok;

`ifdef SAMPLER_SYNC_EN
   logic [CHLS-1:0] r_sync1;
   logic [CHLS-1:0] r_sync2;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= chls_i;
         r_sync2 <= r_sync1;
      end
   end

   assign w_chls = r_sync2;
`else
   assign w_chls = chls_i;
`endif

   // Channel bit gi belongs to group gi/8; a set disable bit zeroes the whole byte.
   generate
      for (genvar gi = 0; gi < CHLS; gi++) begin : g_keep
         assign w_keep[gi] = ~r_grp_dis[gi/8];
      end
   endgenerate

   assign w_src    = r_test ? r_tpat[CHLS-1:0] : w_chls;
   assign w_masked = w_src & w_keep;
   assign w_fire   = en_i && !set_div_i && (r_cnt == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_div     <= '0;
         r_cnt     <= '0;
         r_grp_dis <= 4'b0;
         r_test    <= 1'b0;
         r_tpat    <= '0;
         r_smpls   <= '0;
         r_stb     <= 1'b0;
      end else begin
         if (set_flags_i) begin
            r_grp_dis <= cmd_i[5:2];
            r_test    <= cmd_i[10];
         end

         if (set_div_i) begin
            r_div <= cmd_i[WDIV-1:0];
            r_cnt <= cmd_i[WDIV-1:0];
            r_stb <= 1'b0;
         end else if (!en_i) begin
            r_cnt <= r_div;
            r_stb <= 1'b0;
         end else if (w_fire) begin
            r_cnt   <= r_div;
            r_stb   <= 1'b1;
            r_smpls <= w_masked;
         end else begin
            r_cnt <= r_cnt - WDIV'(1);
            r_stb <= 1'b0;
         end

         // Entering test mode restarts the pattern so the first test sample is 0.
         if (set_flags_i && cmd_i[10] && !r_test)
            r_tpat <= '0;
         else if (w_fire && r_test)
            r_tpat <= r_tpat + 32'd1;
      end
   end

   assign smpls_o = r_smpls;
   assign stb_o   = r_stb;

   assign w_unused_ok = ^{cmd_i, r_grp_dis, r_tpat};

endmodule
